// File: rtl/vram_window_scanout.sv
// ---------------------------------------------------------------------------
// vram_window_scanout
//
// Purpose: scan-out stage between the LCD timing generator / video RAM and
// the LCD pins. For a rectangular window it turns the pixel/line counters
// into a scaled video-RAM read address. It waits out the RAM read latency and
// drives RGB565 pixels. Sync and DE are delayed by the same amount, so every
// LCD output stays cycle-aligned. Outside the window a generated background
// (pix_x + pix_y) is shown. The window enable only changes on a vsync falling
// edge.
//
// Optional feature: define VRAM_SCANOUT_BORDER_EN to draw a white 1-pixel
// ring just outside the window while the window is enabled.
//
// Ports:
//   pixel_clk   in   pixel clock, posedge
//   rst         in   asynchronous active-low reset
//   pix_x/pix_y in   16-bit pixel column / line from the timing generator
//   de_in       in   data enable
//   hs_in/vs_in in   hsync / vsync, active low
//   win_en_req  in   requested window enable, sampled at vsync fall
//   rd_addr     out  registered video RAM read address
//   rd_ce       out  registered video RAM read clock-enable
//   rd_data     in   RAM read data, RGB666 {R6,G6,B6}
//   lcd_de/hs/vs out delayed DE / hsync / vsync
//   lcd_rgb     out  RGB565 pixel
//   frame_cnt   out  frames completed since reset (wraps)
// ---------------------------------------------------------------------------
module vram_window_scanout #(
    parameter int START_X     = 160,
    parameter int START_Y     = 18,
    parameter int WIN_W       = 256,
    parameter int WIN_H       = 256,
    parameter int SCALE_SHIFT = 3,
    parameter int COLS_LOG2   = 5,
    parameter int ADDR_W      = 10,
    parameter int RD_LAT      = 1
) (
    input  logic              pixel_clk,
    input  logic              rst,
    input  logic [15:0]       pix_x,
    input  logic [15:0]       pix_y,
    input  logic              de_in,
    input  logic              hs_in,
    input  logic              vs_in,
    input  logic              win_en_req,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ce,
    input  logic [17:0]       rd_data,
    output logic              lcd_de,
    output logic              lcd_hs,
    output logic              lcd_vs,
    output logic [15:0]       lcd_rgb,
    output logic [7:0]        frame_cnt
);

    // Total latency: one cycle for the address register plus the RAM latency.
    localparam int L = 1 + RD_LAT;

    typedef enum logic {
        WIN_OFF = 1'b0,
        WIN_ON  = 1'b1
    } win_state_t;

    // Everything that must travel alongside the RAM read to the output mux.
    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic        in_win;
        logic        border;
        logic [15:0] bg;
    } stage_t;

    localparam stage_t STAGE_RST = '{de: 1'b0, hs: 1'b1, vs: 1'b1,
                                     in_win: 1'b0, border: 1'b0, bg: 16'h0000};

    win_state_t        win_state_q, win_state_d;
    logic              vs_q, vs_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_ce_q, rd_ce_d;
    stage_t            pipe_q [L];
    stage_t            pipe_d [L];

    logic              win_en;
    logic              vs_fall;
    logic              in_win;
    logic              border;
    logic [31:0]       px_u, py_u, dx, dy, addr_full;
    logic [15:0]       rgb_mux;
    stage_t            out_s;
    logic              unused_bits;

    assign win_en = (win_state_q == WIN_ON);

    // Window test and scaled address, all unsigned in 32 bits so that
    // START_X + WIN_W never overflows the comparison.
    always_comb begin
        px_u      = {16'd0, pix_x};
        py_u      = {16'd0, pix_y};
        in_win    = win_en
                    && (px_u >= START_X) && (px_u < START_X + WIN_W)
                    && (py_u >= START_Y) && (py_u < START_Y + WIN_H);
        dx        = px_u - START_X;
        dy        = py_u - START_Y;
        addr_full = ((dy >> SCALE_SHIFT) << COLS_LOG2) | (dx >> SCALE_SHIFT);
    end

`ifdef VRAM_SCANOUT_BORDER_EN
    // Ring just outside the window. Signed compares let START_X-1 / START_Y-1
    // go negative, and no counter value can match a negative value.
    logic signed [31:0] px_s, py_s;
    logic               on_x_edge, on_y_edge, x_span, y_span;
    always_comb begin
        px_s      = signed'(px_u);
        py_s      = signed'(py_u);
        on_x_edge = (px_s == START_X - 1) || (px_s == START_X + WIN_W);
        on_y_edge = (py_s == START_Y - 1) || (py_s == START_Y + WIN_H);
        x_span    = (px_s >= START_X - 1) && (px_s <= START_X + WIN_W);
        y_span    = (py_s >= START_Y - 1) && (py_s <= START_Y + WIN_H);
        border    = win_en && de_in
                    && ((on_x_edge && y_span) || (on_y_edge && x_span));
    end
`else
    assign border = 1'b0;
`endif

    // Window-enable FSM and frame counter, both advanced on vsync fall.
    always_comb begin
        win_state_d = win_state_q;
        frame_cnt_d = frame_cnt_q;
        vs_d        = vs_in;
        vs_fall     = vs_q && !vs_in;
        if (vs_fall) begin
            win_state_d = win_en_req ? WIN_ON : WIN_OFF;
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    // Stage 1 address register; the address holds while no read is issued.
    always_comb begin
        rd_ce_d   = in_win && de_in;
        rd_addr_d = rd_ce_d ? addr_full[ADDR_W-1:0] : rd_addr_q;
    end

    always_comb begin
        pipe_d[0] = '{de: de_in, hs: hs_in, vs: vs_in, in_win: in_win,
                      border: border, bg: pix_x + pix_y};
        for (int i = 1; i < L; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge pixel_clk or negedge rst) begin
        if (!rst) begin
            win_state_q <= WIN_OFF;
            vs_q        <= 1'b1;
            frame_cnt_q <= 8'd0;
            rd_addr_q   <= '0;
            rd_ce_q     <= 1'b0;
            for (int i = 0; i < L; i++) begin
                pipe_q[i] <= STAGE_RST;
            end
        end else begin
            win_state_q <= win_state_d;
            vs_q        <= vs_d;
            frame_cnt_q <= frame_cnt_d;
            rd_addr_q   <= rd_addr_d;
            rd_ce_q     <= rd_ce_d;
            for (int i = 0; i < L; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    // The last pipeline stage lines up with rd_data, so the output mux
    // is combinational on purpose.
    always_comb begin
        out_s = pipe_q[L-1];
        if (!out_s.de) begin
            rgb_mux = 16'h0000;
        end else if (out_s.in_win) begin
            rgb_mux = {rd_data[17:13], rd_data[11:6], rd_data[5:1]};
        end else if (out_s.border) begin
            rgb_mux = 16'hFFFF;
        end else begin
            rgb_mux = out_s.bg;
        end
    end

    // RGB666 -> RGB565 drops the R and B LSBs; upper address bits wrap.
    assign unused_bits = ^{rd_data[12], rd_data[0], addr_full[31:ADDR_W]};

    assign rd_addr   = rd_addr_q;
    assign rd_ce     = rd_ce_q;
    assign lcd_de    = out_s.de;
    assign lcd_hs    = out_s.hs;
    assign lcd_vs    = out_s.vs;
    assign lcd_rgb   = rgb_mux;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vram_window_scanout.sv
module tb_vram_window_scanout;

    localparam int RD_LAT = 1;
    localparam int L      = RD_LAT + 1;
    localparam int SX     = 160;
    localparam int SY     = 18;
    localparam int W      = 256;
    localparam int H      = 256;

    logic        pixel_clk = 1'b0;
    logic        rst       = 1'b0;
    logic [15:0] pix_x     = 16'd0;
    logic [15:0] pix_y     = 16'd0;
    logic        de_in     = 1'b0;
    logic        hs_in     = 1'b1;
    logic        vs_in     = 1'b1;
    logic        win_en_req = 1'b0;
    logic [9:0]  rd_addr;
    logic        rd_ce;
    logic [17:0] rd_data;
    logic        lcd_de, lcd_hs, lcd_vs;
    logic [15:0] lcd_rgb;
    logic [7:0]  frame_cnt;

    vram_window_scanout #(.RD_LAT(RD_LAT)) dut (
        .pixel_clk  (pixel_clk),
        .rst        (rst),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .de_in      (de_in),
        .hs_in      (hs_in),
        .vs_in      (vs_in),
        .win_en_req (win_en_req),
        .rd_addr    (rd_addr),
        .rd_ce      (rd_ce),
        .rd_data    (rd_data),
        .lcd_de     (lcd_de),
        .lcd_hs     (lcd_hs),
        .lcd_vs     (lcd_vs),
        .lcd_rgb    (lcd_rgb),
        .frame_cnt  (frame_cnt)
    );

    always #5 pixel_clk = ~pixel_clk;

    // Video RAM contents; word 0 is all ones.
    function automatic logic [17:0] mem_word(input logic [9:0] a);
        if (a == 10'd0) return 18'h3FFFF;
        return {a[9:4], a[5:0] ^ 6'h2A, a[8:3] ^ 6'h15};
    endfunction

    // RAM model: RD_LAT cycles from registered address to data.
    logic [17:0] ram_q [RD_LAT];
    initial for (int i = 0; i < RD_LAT; i++) ram_q[i] = 18'd0;
    always @(posedge pixel_clk) begin
        ram_q[0] <= mem_word(rd_addr);
        for (int i = 1; i < RD_LAT; i++) ram_q[i] <= ram_q[i-1];
    end
    assign rd_data = ram_q[RD_LAT-1];

    int cyc = 0;
    always @(posedge pixel_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int          due;
        logic        de;
        logic        hs;
        logic        vs;
        logic [15:0] rgb;
    } out_exp_t;
    typedef struct {
        int         due;
        logic       ce;
        logic [9:0] addr;
    } rd_exp_t;

    out_exp_t out_q[$];
    rd_exp_t  rd_q[$];

    // Reference model state
    logic       win_m     = 1'b0;
    logic       vs_q_m    = 1'b1;
    logic       vs_last   = 1'b1;
    logic       req_last  = 1'b0;
    int         frame_m   = 0;
    logic [9:0] addr_hold = 10'd0;

    function automatic logic on_ring(input int x, input int y);
        return ((x == SX - 1 || x == SX + W) && y >= SY - 1 && y <= SY + H)
            || ((y == SY - 1 || y == SY + H) && x >= SX - 1 && x <= SX + W);
    endfunction

    // Drive one pixel cycle and push the expected results.
    task automatic drive(input int x, input int y, input logic de,
                         input logic hs, input logic vs, input logic req);
        logic        inwin, ce, brd;
        logic [15:0] rgb, xs, ys;
        logic [17:0] d;
        out_exp_t    oe;
        rd_exp_t     re;
        @(negedge pixel_clk);
        if (vs_q_m && !vs_last) begin
            win_m   = req_last;
            frame_m = (frame_m + 1) % 256;
        end
        vs_q_m = vs_last;
        xs = x[15:0];
        ys = y[15:0];
        pix_x = xs; pix_y = ys; de_in = de; hs_in = hs; vs_in = vs;
        win_en_req = req;
        inwin = win_m && x >= SX && x < SX + W && y >= SY && y < SY + H;
        ce = inwin && de;
        if (ce) addr_hold = 10'(((y - SY) / 8) * 32 + (x - SX) / 8);
`ifdef VRAM_SCANOUT_BORDER_EN
        brd = win_m && de && on_ring(x, y);
`else
        brd = 1'b0;
`endif
        d = mem_word(addr_hold);
        if (!de)        rgb = 16'h0000;
        else if (inwin) rgb = {d[17:13], d[11:6], d[5:1]};
        else if (brd)   rgb = 16'hFFFF;
        else            rgb = xs + ys;
        re.due = cyc + 1; re.ce = ce; re.addr = addr_hold;
        rd_q.push_back(re);
        oe.due = cyc + L; oe.de = de; oe.hs = hs; oe.vs = vs; oe.rgb = rgb;
        out_q.push_back(oe);
        vs_last  = vs;
        req_last = req;
    endtask

    task automatic vs_pulse(input logic req);
        drive(0, 0, 1'b0, 1'b1, 1'b0, req);
        drive(0, 0, 1'b0, 1'b1, 1'b0, req);
        drive(0, 0, 1'b0, 1'b1, 1'b1, req);
    endtask

    // Release reset; the first L output cycles still show reset values.
    task automatic release_reset();
        out_exp_t oe;
        rd_exp_t  re;
        @(negedge pixel_clk);
        rst = 1'b1;
        for (int k = 1; k <= L; k++) begin
            oe.due = cyc + k; oe.de = 1'b0; oe.hs = 1'b1; oe.vs = 1'b1;
            oe.rgb = 16'h0000;
            out_q.push_back(oe);
        end
        re.due = cyc + 1; re.ce = 1'b0; re.addr = 10'd0;
        rd_q.push_back(re);
    endtask

    // Scoreboard: pop each expectation when its output cycle arrives.
    out_exp_t mo;
    rd_exp_t  mr;
    always @(negedge pixel_clk) begin
        while (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
            mr = rd_q.pop_front();
            n_checks++;
            if (mr.due != cyc || rd_ce !== mr.ce) begin
                n_errors++;
                $display("FAIL rd_ce cyc=%0d due=%0d got=%b exp=%b", cyc, mr.due, rd_ce, mr.ce);
            end else begin
                $display("rd   cyc=%0d rd_ce=%b rd_addr=%0d", cyc, rd_ce, rd_addr);
            end
            if (mr.ce) begin
                n_checks++;
                if (rd_addr !== mr.addr) begin
                    n_errors++;
                    $display("FAIL rd_addr cyc=%0d got=%0d exp=%0d", cyc, rd_addr, mr.addr);
                end
            end
        end
        while (out_q.size() > 0 && out_q[0].due <= cyc) begin
            mo = out_q.pop_front();
            n_checks++;
            if (mo.due != cyc || lcd_de !== mo.de || lcd_hs !== mo.hs || lcd_vs !== mo.vs
                || lcd_rgb !== mo.rgb) begin
                n_errors++;
                $display("FAIL lcd_out cyc=%0d due=%0d got de/hs/vs/rgb=%b%b%b/%h exp=%b%b%b/%h",
                         cyc, mo.due, lcd_de, lcd_hs, lcd_vs, lcd_rgb, mo.de, mo.hs, mo.vs, mo.rgb);
            end else begin
                $display("out  cyc=%0d de=%b hs=%b vs=%b rgb=%h", cyc, lcd_de, lcd_hs, lcd_vs, lcd_rgb);
            end
        end
    end

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge pixel_clk);
        n_checks++;
        if (lcd_hs !== 1'b1 || lcd_vs !== 1'b1 || lcd_de !== 1'b0 || lcd_rgb !== 16'h0000
            || rd_ce !== 1'b0 || frame_cnt !== 8'd0 || rd_addr !== 10'd0) begin
            n_errors++;
            $display("FAIL reset got hs=%b vs=%b de=%b rgb=%h ce=%b fc=%0d addr=%0d exp 1 1 0 0000 0 0 0",
                     lcd_hs, lcd_vs, lcd_de, lcd_rgb, rd_ce, frame_cnt, rd_addr);
        end
        release_reset();
    endtask

    task automatic test_window();
        int xs[12] = '{160, 161, 168, 415, 416, 159, 416, 300, 159, 100, 415, 160};
        int ys[12] = '{18,  18,  26,  273, 273, 18,  274, 100, 17,  5,   17,  274};
        drive(0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
        vs_pulse(1'b1);
        n_checks++;
        if (frame_cnt !== 8'd1) begin
            n_errors++;
            $display("FAIL frame_first got=%0d exp=1", frame_cnt);
        end
        for (int i = 0; i < 12; i++) drive(xs[i], ys[i], 1'b1, 1'b1, 1'b1, 1'b1);
        drive(200, 100, 1'b0, 1'b0, 1'b1, 1'b1);
        drive(200, 100, 1'b1, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic test_win_toggle();
        int f0;
        vs_pulse(1'b0);
        f0 = frame_m;
        for (int i = 0; i < 4; i++) drive(200 + i, 100, 1'b1, 1'b1, 1'b1, 1'b1);
        drive(160, 18, 1'b1, 1'b1, 1'b1, 1'b1);
        vs_pulse(1'b1);
        n_checks++;
        if (frame_cnt !== 8'(f0 + 1)) begin
            n_errors++;
            $display("FAIL frame_toggle got=%0d exp=%0d", frame_cnt, 8'(f0 + 1));
        end
        drive(200, 100, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(160, 18, 1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_sync_pattern();
        for (int i = 0; i < 48; i++) begin
            drive(int'($urandom_range(140, 430)), int'($urandom_range(10, 280)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 5) != 0), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_midframe_reset();
        vs_pulse(1'b1);
        drive(170, 30, 1'b1, 1'b0, 1'b1, 1'b1);
        drive(171, 30, 1'b1, 1'b1, 1'b1, 1'b1);
        @(negedge pixel_clk);
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (lcd_hs !== 1'b1 || lcd_vs !== 1'b1 || lcd_de !== 1'b0 || lcd_rgb !== 16'h0000
            || rd_ce !== 1'b0 || frame_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL midreset got hs=%b vs=%b de=%b rgb=%h ce=%b fc=%0d exp 1 1 0 0000 0 0",
                     lcd_hs, lcd_vs, lcd_de, lcd_rgb, rd_ce, frame_cnt);
        end
        out_q.delete();
        rd_q.delete();
        pix_x = 16'd0; pix_y = 16'd0; de_in = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
        win_en_req = 1'b0;
        win_m = 1'b0; vs_q_m = 1'b1; vs_last = 1'b1; req_last = 1'b0;
        frame_m = 0; addr_hold = 10'd0;
        @(negedge pixel_clk);
        release_reset();
        drive(170, 30, 1'b1, 1'b1, 1'b1, 1'b1);
        vs_pulse(1'b1);
        drive(170, 30, 1'b1, 1'b1, 1'b1, 1'b1);
        drive(415, 273, 1'b1, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        test_reset();
        test_window();
        test_win_toggle();
        test_sync_pattern();
        test_midframe_reset();
        drive(0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (L + 2) @(negedge pixel_clk);
        #1;
        n_checks++;
        if (out_q.size() != 0 || rd_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain got pending=%0d/%0d exp 0/0", out_q.size(), rd_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vram_window_scanout.md
Name: vram_window_scanout

Overview:
- Scan-out stage between the LCD timing generator / video RAM and the LCD pins.
- Takes pixel/line counters and sync/DE, computes a scaled video-RAM read address for a rectangular window, and waits out the RAM read latency.
- Drives RGB565 pixels plus sync/DE delayed by the same amount, so all LCD outputs stay cycle-aligned.
- Outside the window it draws a generated background pattern. Window enable changes only at frame boundaries.

Parameters:
- START_X, 160: first screen column inside the window.
- START_Y, 18: first screen line inside the window.
- WIN_W, 256: window width in screen pixels.
- WIN_H, 256: window height in screen lines.
- SCALE_SHIFT, 3: each RAM word covers 2^SCALE_SHIFT × 2^SCALE_SHIFT screen pixels.
- COLS_LOG2, 5: log2 of RAM words per image row.
- ADDR_W, 10: video RAM address width.
- RD_LAT, 1: RAM read latency, cycles from registered address to valid rd_data (≥1).

Ports:
- pixel_clk  in  1  pixel clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- pix_x  in  16  current pixel column from the timing generator.
- pix_y  in  16  current line from the timing generator.
- de_in  in  1  data enable from the timing generator.
- hs_in  in  1  hsync, active low.
- vs_in  in  1  vsync, active low.
- win_en_req  in  1  requested window enable; frame-synchronous.
- rd_addr  out  ADDR_W  video RAM read address (registered).
- rd_ce  out  1  video RAM read clock-enable (registered).
- rd_data  in  18  RAM read data, RGB666 as {R[5:0],G[5:0],B[5:0]}.
- lcd_de  out  1  delayed DE.
- lcd_hs  out  1  delayed hsync.
- lcd_vs  out  1  delayed vsync.
- lcd_rgb  out  16  RGB565 pixel {R5,G6,B5}.
- frame_cnt  out  8  frames completed since reset; wraps.

Behaviour:
- Reset (rst=0, async), all registers cleared:
  - rd_addr=0, rd_ce=0, lcd_de=0, lcd_rgb=0, frame_cnt=0, win_en=0.
  - lcd_hs=1 and lcd_vs=1 (inactive); all pipeline stages hold these values.
- Window test, unsigned:
  - in_win = win_en & START_X ≤ pix_x < START_X+WIN_W & START_Y ≤ pix_y < START_Y+WIN_H.
  - pix_x = START_X+WIN_W−1 is inside; START_X+WIN_W is outside. Same rule applies on y.
- Address:
  - col = (pix_x−START_X)>>SCALE_SHIFT; row = (pix_y−START_Y)>>SCALE_SHIFT.
  - rd_addr = (row<<COLS_LOG2)|col, truncated to ADDR_W LSBs; excess bits wrap.
  - Defaults: 32×32 words, full 1024-word RAM.
- Stage 1 (cycle after input):
  - Register rd_addr and rd_ce = in_win & de_in.
  - rd_addr holds its last value when rd_ce=0.
- Pipeline latency L = 1+RD_LAT. Inputs sampled at cycle t appear on lcd_* at t+L.
  - Delay line of depth L carries de, hs, vs, the in_win flag, and the background colour.
- Output mux at stage L:
  - delayed de=0 → lcd_rgb=0.
  - else delayed in_win=1 → lcd_rgb = {d[17:13], d[11:6], d[5:1]} of rd_data.
  - else → background = (pix_x+pix_y)[15:0] sampled at t.
- Window-enable state machine:
  - States WIN_OFF and WIN_ON; reset state WIN_OFF.
  - On each vs_in falling edge (registered vs_in =1, current =0), win_en ← win_en_req.
  - Changes of win_en_req mid-frame have no effect until the next falling edge.
- frame_cnt increments on the same vs_in falling edge, modulo 256.
- Mid-frame reset: outputs take reset values immediately. After release the pipeline refills; the first L output cycles show the reset values (de=0, hs=vs=1).

Optional Feature:
- Macro VRAM_SCANOUT_BORDER_EN.
- When defined and win_en=1: pixels with de_in=1 forming a 1-pixel ring immediately outside the window output lcd_rgb=16'hFFFF. The ring is x = START_X−1 or START_X+WIN_W with y inside [START_Y−1, START_Y+WIN_H], and the symmetric case for y.
  - The ring is not emitted at any coordinate below 0.
- When undefined: no border logic; those pixels show background.

Test Plan:
- Reset with rst=0, clock running → lcd_hs=1, lcd_vs=1, lcd_de=0, lcd_rgb=0, rd_ce=0, frame_cnt=0.
- win_en_req=1 before a vs_in fall; pix_x=160, pix_y=18, de_in=1 → next cycle rd_addr=0, rd_ce=1. RAM returns 18'h3FFFF → lcd_rgb=16'hFFFF exactly 2 cycles after input (RD_LAT=1).
- pix_x=415, pix_y=273 → rd_addr=1023. pix_x=416 → rd_ce=0, lcd_rgb=(416+273)=16'h02B1.
- Toggle win_en_req 0→1 mid-frame at pix (200,100) → window pixels stay background until after the next vs_in fall; frame_cnt increments by 1 at that fall.
- hs_in/vs_in/de_in pulse pattern → lcd_hs/lcd_vs/lcd_de reproduce it shifted exactly L=2 cycles. RD_LAT=3 build → shift 4.
- With VRAM_SCANOUT_BORDER_EN defined, win_en=1: pixels (159,18) and (416,274) → 16'hFFFF. Without the macro → background values.
